counter_bn: RTL and testbench

//  Parametrised up/down/step/load counter; next generation of the 4-bit mode counter.

---
 rtl/counter_bn.sv | 73 +++++++
 tb/tb_counter_bn.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_bn.sv
// Up/down/step/load counter with registered wrap flag and load strobe.
// Define COUNTER_BN_SAT_EN to saturate at the limits instead of wrapping.
module counter_bn #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 3
) (
   input  logic             bn_clk,
   input  logic             bn_reset,
   input  logic             bn_enable,
   input  logic [1:0]       bn_mode,
   input  logic [WIDTH-1:0] bn_D,
   output logic [WIDTH-1:0] bn_Q,
   output logic             bn_rco,
   output logic             bn_load
);

   localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] OneExt  = (WIDTH+1)'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             rco_q, rco_d;
   logic             load_q, load_d;
   logic [WIDTH:0]   sum;

   // Extra MSB of sum is the carry (up) or borrow (down) that marks a wrap.
   always_comb begin
      sum = {1'b0, q_q};
      unique case (bn_mode)
         2'b00: sum = {1'b0, q_q} + OneExt;
         2'b01: sum = {1'b0, q_q} - OneExt;
         2'b10: sum = {1'b0, q_q} + StepExt;
         2'b11: sum = {1'b0, bn_D};
      endcase
   end

   always_comb begin
      q_d    = q_q;
      rco_d  = 1'b0;
      load_d = 1'b0;
      if (bn_enable) begin
         if (bn_mode == 2'b11) begin
            q_d    = bn_D;
            load_d = 1'b1;
         end else if (sum[WIDTH]) begin
            rco_d = 1'b1;
`ifdef COUNTER_BN_SAT_EN
            q_d = (bn_mode == 2'b01) ? '0 : '1;
`else
            q_d = sum[WIDTH-1:0];
`endif
         end else begin
            q_d = sum[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge bn_clk or negedge bn_reset) begin
      if (!bn_reset) begin
         q_q    <= '0;
         rco_q  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         rco_q  <= rco_d;
         load_q <= load_d;
      end
   end

   assign bn_Q    = q_q;
   assign bn_rco  = rco_q;
   assign bn_load = load_q;

endmodule

// File: tb/tb_counter_bn.sv
// Bench for counter_bn: a WIDTH=4/STEP=3 and a WIDTH=8/STEP=5 instance share control inputs.
// Honours COUNTER_BN_SAT_EN the same way the design does.
module tb_counter_bn;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] d4 = '0;
   logic [7:0] d8 = '0;
   logic [3:0] q4;
   logic [7:0] q8;
   logic       rco4, load4, rco8, load8;

   int total = 0;
   int bad = 0;

   int  m4_q = 0, m8_q = 0;
   bit  m4_r = 0, m4_l = 0, m8_r = 0, m8_l = 0;

   always #5 clk = ~clk;

   counter_bn #(.WIDTH(4), .STEP(3)) u_dut4 (
      .bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_mode(mode),
      .bn_D(d4), .bn_Q(q4), .bn_rco(rco4), .bn_load(load4)
   );

   counter_bn #(.WIDTH(8), .STEP(5)) u_dut8 (
      .bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_mode(mode),
      .bn_D(d8), .bn_Q(q8), .bn_rco(rco8), .bn_load(load8)
   );

   // Reference: plain integer arithmetic against the range [0, 2**w-1].
   function automatic void model(input int w, input int stp, input int q, input bit e,
                                 input logic [1:0] m, input int d,
                                 output int nq, output bit nr, output bit nl);
      int lim;
      int s;
      lim = (1 << w) - 1;
      nq = q; nr = 0; nl = 0;
      if (!e) return;
      case (m)
         2'b00: s = q + 1;
         2'b01: s = q - 1;
         2'b10: s = q + stp;
         default: begin nq = d; nl = 1; return; end
      endcase
`ifdef COUNTER_BN_SAT_EN
      if (s > lim) begin nq = lim; nr = 1; end
      else if (s < 0) begin nq = 0; nr = 1; end
      else nq = s;
`else
      if (s > lim) begin nq = s - (lim + 1); nr = 1; end
      else if (s < 0) begin nq = s + (lim + 1); nr = 1; end
      else nq = s;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m4_q = 0; m4_r = 0; m4_l = 0;
      m8_q = 0; m8_r = 0; m8_l = 0;
   endtask

   // One clock: drive inputs, advance both models, compare the 8-bit DUT (and 4-bit if asked).
   task automatic step(input bit e, input logic [1:0] m, input logic [3:0] v4,
                       input logic [7:0] v8, input bit chk4);
      int nq; bit nr, nl;
      en = e; mode = m; d4 = v4; d8 = v8;
      model(4, 3, m4_q, e, m, int'(v4), nq, nr, nl);
      m4_q = nq; m4_r = nr; m4_l = nl;
      model(8, 5, m8_q, e, m, int'(v8), nq, nr, nl);
      m8_q = nq; m8_r = nr; m8_l = nl;
      @(posedge clk);
      #1;
      check("q8", int'(q8), m8_q);
      check("rco8", int'(rco8), int'(m8_r));
      check("load8", int'(load8), int'(m8_l));
      if (chk4) begin
         check("q4", int'(q4), m4_q);
         check("rco4", int'(rco4), int'(m4_r));
         check("load4", int'(load4), int'(m4_l));
      end
   endtask

   typedef struct {
      bit         en;
      logic [1:0] mode;
      logic [3:0] d;
      int         q;
      bit         rco;
      bit         load;
   } vec_t;

   vec_t tbl[12];

   initial begin
`ifdef COUNTER_BN_SAT_EN
      tbl[0]  = '{1, 2'b01, 4'h0,  0, 1, 0};
      tbl[1]  = '{1, 2'b11, 4'hE, 14, 0, 1};
      tbl[2]  = '{1, 2'b10, 4'h0, 15, 1, 0};
      tbl[3]  = '{1, 2'b10, 4'h0, 15, 1, 0};
      tbl[4]  = '{1, 2'b00, 4'h0, 15, 1, 0};
      tbl[5]  = '{1, 2'b01, 4'h0, 14, 0, 0};
      tbl[6]  = '{0, 2'b01, 4'h0, 14, 0, 0};
      tbl[7]  = '{1, 2'b11, 4'hA, 10, 0, 1};
      tbl[8]  = '{1, 2'b11, 4'h1,  1, 0, 1};
      tbl[9]  = '{1, 2'b01, 4'h0,  0, 0, 0};
      tbl[10] = '{1, 2'b01, 4'h0,  0, 1, 0};
      tbl[11] = '{1, 2'b10, 4'h0,  3, 0, 0};
`else
      tbl[0]  = '{1, 2'b01, 4'h0, 15, 1, 0};
      tbl[1]  = '{1, 2'b01, 4'h0, 14, 0, 0};
      tbl[2]  = '{1, 2'b10, 4'h0,  1, 1, 0};
      tbl[3]  = '{1, 2'b10, 4'h0,  4, 0, 0};
      tbl[4]  = '{1, 2'b11, 4'hA, 10, 0, 1};
      tbl[5]  = '{0, 2'b00, 4'h0, 10, 0, 0};
      tbl[6]  = '{1, 2'b11, 4'hF, 15, 0, 1};
      tbl[7]  = '{1, 2'b11, 4'hE, 14, 0, 1};
      tbl[8]  = '{1, 2'b00, 4'h0, 15, 0, 0};
      tbl[9]  = '{1, 2'b00, 4'h0,  0, 1, 0};
      tbl[10] = '{1, 2'b00, 4'h0,  1, 0, 0};
      tbl[11] = '{0, 2'b01, 4'h0,  1, 0, 0};
`endif

      // Reset state, with enable high and mode 01 pending across the release.
      en = 1'b1; mode = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q4", int'(q4), 0);
      check("rst_rco4", int'(rco4), 0);
      check("rst_load4", int'(load4), 0);
      check("rst_q8", int'(q8), 0);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].en, tbl[i].mode, tbl[i].d, 8'h00, 1'b0);
         check($sformatf("tbl%0d_q", i), int'(q4), tbl[i].q);
         check($sformatf("tbl%0d_rco", i), int'(rco4), int'(tbl[i].rco));
         check($sformatf("tbl%0d_load", i), int'(load4), int'(tbl[i].load));
      end

      // 17 up-counts from 0.
      step(1'b1, 2'b11, 4'h0, 8'h00, 1'b1);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 2'b00, 4'h0, 8'h00, 1'b0);
`ifdef COUNTER_BN_SAT_EN
         check("up17_q", int'(q4), (i + 1 > 15) ? 15 : i + 1);
         check("up17_rco", int'(rco4), (i >= 15) ? 1 : 0);
`else
         check("up17_q", int'(q4), (i + 1) % 16);
         check("up17_rco", int'(rco4), (i == 15) ? 1 : 0);
`endif
      end

      // Upper boundary for the 8-bit instance: 254 + 5.
      step(1'b1, 2'b11, 4'h0, 8'd254, 1'b1);
      step(1'b1, 2'b10, 4'h0, 8'd0, 1'b1);
`ifdef COUNTER_BN_SAT_EN
      check("w8_step_q", int'(q8), 255);
`else
      check("w8_step_q", int'(q8), 3);
`endif
      check("w8_step_rco", int'(rco8), 1);

      // Asynchronous reset mid-cycle at Q=9 with load strobe high.
      step(1'b1, 2'b11, 4'h9, 8'h09, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_q4", int'(q4), 0);
      check("async_rco4", int'(rco4), 0);
      check("async_load4", int'(load4), 0);
      check("async_q8", int'(q8), 0);
      model_reset();
      @(posedge clk);
      #1;
      check("held_q4", int'(q4), 0);
      rst_n = 1'b1;

      // Randomised run compared against the model on both instances.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] v8;
         v8 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom);
         step(($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom), v8, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
